// File: rtl/life_pkg.sv
// life_pkg: shared FSM state type and cell indexing for the Game-of-Life engine (rev 1.0).
// Used by life_engine_ctrl and life_next_gen; LIFE_WRAP_EN is consumed in life_next_gen.
`default_nettype none
package life_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    RUN   = 2'd2
  } life_state_t;

  function automatic int cell_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_next_gen.sv
// life_next_gen: combinational B3/S23 next-generation grid (rev 1.0).
// LIFE_WRAP_EN defined -> toroidal neighbours; undefined -> fixed dead border.
`default_nettype none
module life_next_gen
  import life_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic [ROWS*COLS-1:0] i_grid,
  output logic [ROWS*COLS-1:0] o_next
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] w_nb;
      logic [3:0] w_cnt;

      // neighbour k walks the 3x3 window row by row, skipping the centre
      for (genvar k = 0; k < 8; k++) begin : g_nb
        localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
        localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                            ((k == 1 || k == 6) ? 0 : 1);
        localparam int NR = r + DR;
        localparam int NC = c + DC;
`ifdef LIFE_WRAP_EN
        assign w_nb[k] = i_grid[cell_idx((NR + ROWS) % ROWS, (NC + COLS) % COLS, COLS)];
`else
        if (NR >= 0 && NR < ROWS && NC >= 0 && NC < COLS) begin : g_in
          assign w_nb[k] = i_grid[cell_idx(NR, NC, COLS)];
        end else begin : g_out
          assign w_nb[k] = 1'b0;
        end
`endif
      end

      always_comb begin
        w_cnt = 4'd0;
        for (int k = 0; k < 8; k++) begin
          w_cnt = w_cnt + {3'b000, w_nb[k]};
        end
      end

      assign o_next[cell_idx(r, c, COLS)] =
        (w_cnt == 4'd3) | (i_grid[cell_idx(r, c, COLS)] & (w_cnt == 4'd2));
    end
  end

endmodule
`default_nettype wire

// File: rtl/life_engine_ctrl.sv
// life_engine_ctrl: Game-of-Life load/run/pause/step engine with rate divider and status (rev 1.0).
// Optional LIFE_WRAP_EN selects a toroidal board inside life_next_gen.
`default_nettype none
module life_engine_ctrl
  import life_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int RATE_W = 24,
  parameter int GEN_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   run,
  input  logic                   step,
  input  logic [RATE_W-1:0]      rate,
  input  logic [ROWS*COLS-1:0]   seed,
  output logic [ROWS*COLS-1:0]   grid,
  output logic [GEN_W-1:0]       generation,
  output logic                   running,
  output logic                   stable,
  output logic                   extinct
);

  localparam int N = ROWS * COLS;

  life_state_t       r_state;
  life_state_t       w_state_nxt;
  logic [N-1:0]      r_grid;
  logic [N-1:0]      w_next_grid;
  logic [GEN_W-1:0]  r_gen;
  logic [RATE_W-1:0] r_tick;
  logic              r_stable;
  logic              w_evolve;
  logic              w_tick_run;

  life_next_gen #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_next_gen (
    .i_grid (r_grid),
    .o_next (w_next_grid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = run ? RUN : PAUSE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        PAUSE:   w_state_nxt = run ? RUN : PAUSE;
        RUN:     w_state_nxt = run ? RUN : PAUSE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // load outranks both a manual step and a tick-due evolve
  always_comb begin
    w_evolve   = 1'b0;
    w_tick_run = 1'b0;
    if (!load) begin
      case (r_state)
        PAUSE: w_evolve = step;
        RUN: begin
          if (run) begin
            w_tick_run = 1'b1;
            w_evolve   = (r_tick == rate);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grid   <= '0;
      r_gen    <= '0;
      r_tick   <= '0;
      r_stable <= 1'b0;
    end else begin
      if (load) begin
        r_grid   <= seed;
        r_gen    <= '0;
        r_stable <= 1'b0;
      end else if (w_evolve) begin
        r_grid   <= w_next_grid;
        r_stable <= (w_next_grid == r_grid);
        if (r_gen != {GEN_W{1'b1}}) begin
          r_gen <= r_gen + {{(GEN_W-1){1'b0}}, 1'b1};
        end
      end
      // tick >= rate also covers a rate lowered below the current count
      if (!w_tick_run || r_tick >= rate) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + {{(RATE_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign grid       = r_grid;
  assign generation = r_gen;
  assign running    = (r_state == RUN);
  assign stable     = r_stable;
  assign extinct    = ~|r_grid;

endmodule
`default_nettype wire

// File: tb/tb_life_engine_ctrl.sv
// tb_life_engine_ctrl: directed table plus hand-written sequences for life_engine_ctrl (8x8).
// Expected edge-case grids depend on LIFE_WRAP_EN.
`default_nettype none
module tb_life_engine_ctrl;

  localparam logic [63:0] BL   = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BV   = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLK  = 64'h0000_0000_0000_0303;
  localparam logic [63:0] EDG  = 64'h0000_0000_0000_0083;
`ifdef LIFE_WRAP_EN
  localparam logic [63:0] EDG1 = 64'h0100_0000_0000_0101;
  localparam logic [63:0] EDG2 = EDG;
  localparam logic        EDG1_EXT = 1'b0;
  localparam logic        EDG2_EXT = 1'b0;
  localparam logic        EDG2_ST  = 1'b0;
`else
  localparam logic [63:0] EDG1 = 64'h0;
  localparam logic [63:0] EDG2 = 64'h0;
  localparam logic        EDG1_EXT = 1'b1;
  localparam logic        EDG2_EXT = 1'b1;
  localparam logic        EDG2_ST  = 1'b1;
`endif

  logic        clk, reset, load, run, step;
  logic [23:0] rate;
  logic [63:0] seed;
  logic [63:0] grid, grid4;
  logic [15:0] generation;
  logic [3:0]  generation4;
  logic        running, stable, extinct;
  logic        running4, stable4, extinct4;

  int nvec = 0;
  int nmis = 0;

  life_engine_ctrl #(.ROWS(8), .COLS(8), .RATE_W(24), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .load(load), .run(run), .step(step), .rate(rate), .seed(seed),
    .grid(grid), .generation(generation), .running(running), .stable(stable), .extinct(extinct)
  );

  life_engine_ctrl #(.ROWS(8), .COLS(8), .RATE_W(24), .GEN_W(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .run(run), .step(step), .rate(rate), .seed(seed),
    .grid(grid4), .generation(generation4), .running(running4), .stable(stable4), .extinct(extinct4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld, rn, st;
    logic [23:0] rt;
    logic [63:0] sd;
    logic [63:0] e_grid;
    logic [15:0] e_gen;
    logic        e_run, e_st, e_ext;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] eg, input logic [15:0] egen,
                     input logic erun, input logic est, input logic eext);
    nvec++;
    if (grid !== eg || generation !== egen || running !== erun || stable !== est || extinct !== eext) begin
      nmis++;
      $display("FAIL %s: got grid=%h gen=%0d run=%b stable=%b extinct=%b, want grid=%h gen=%0d run=%b stable=%b extinct=%b",
               name, grid, generation, running, stable, extinct, eg, egen, erun, est, eext);
    end
  endtask

  task automatic cyc(input logic ld, input logic rn, input logic st, input logic [23:0] rt,
                     input logic [63:0] sd);
    load = ld; run = rn; step = st; rate = rt; seed = sd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {load, run, step, rate, seed, grid, gen, running, stable, extinct}
    vecs[0] = '{1'b0, 1'b1, 1'b1, 24'd0, BL,  64'h0, 16'd0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 24'd0, BL,  BL,    16'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 24'd0, 64'h0, BV,  16'd1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 24'd0, 64'h0, BL,  16'd2, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 24'd0, 64'h0, BL,  16'd2, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 24'd0, BLK, BLK,   16'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 24'd0, 64'h0, BLK, 16'd1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 24'd0, EDG, EDG,   16'd0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 24'd0, 64'h0, EDG1, 16'd1, 1'b0, 1'b0, EDG1_EXT};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 24'd0, 64'h0, EDG2, 16'd2, 1'b0, EDG2_ST, EDG2_EXT};

    reset = 1'b1; load = 0; run = 0; step = 0; rate = '0; seed = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 64'h0, 16'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].ld, vecs[i].rn, vecs[i].st, vecs[i].rt, vecs[i].sd);
      chk($sformatf("vec%0d", i), vecs[i].e_grid, vecs[i].e_gen, vecs[i].e_run, vecs[i].e_st, vecs[i].e_ext);
    end

    // rate=3: one evolve every 4 cycles after entering RUN
    cyc(1'b1, 1'b1, 1'b0, 24'd3, BL);
    chk("rate3_load", BL, 16'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 24'd3, 64'h0);
      chk($sformatf("rate3_c%0d", k), ((k / 4) % 2 == 1) ? BV : BL, 16'(k / 4), 1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 24'd3, 64'h0);
      chk($sformatf("paused%0d", k), BV, 16'd3, 1'b0, 1'b0, 1'b0);
    end

    // rate=0: re-enter RUN (no evolve on that edge), then one evolve per cycle
    cyc(1'b0, 1'b1, 1'b0, 24'd0, 64'h0);
    chk("rate0_enter", BV, 16'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 24'd0, 64'h0);
      chk($sformatf("rate0_c%0d", k), (k % 2 == 1) ? BL : BV, 16'(3 + k), 1'b1, 1'b0, 1'b0);
    end

    // rate lowered below current tick wraps without evolving
    cyc(1'b1, 1'b1, 1'b0, 24'd5, BL);
    for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b1, 1'b0, 24'd5, 64'h0);
    chk("rate5_t4", BL, 16'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 5; k <= 7; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 24'd2, 64'h0);
      chk($sformatf("ratechg_c%0d", k), BL, 16'd0, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 24'd2, 64'h0);
    chk("ratechg_evolve", BV, 16'd1, 1'b1, 1'b0, 1'b0);

    // reset asserted mid-RUN clears asynchronously
    cyc(1'b0, 1'b1, 1'b0, 24'd0, 64'h0);
    #3 reset = 1'b1;
    #1 chk("async_reset", 64'h0, 16'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 1'b1, 24'd0, 64'h0);
    chk("idle_ignores", 64'h0, 16'd0, 1'b0, 1'b0, 1'b1);

    // generation saturation on the 4-bit instance
    cyc(1'b1, 1'b1, 1'b0, 24'd0, BL);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0, 24'd0, 64'h0);
    chk("run20", BL, 16'd20, 1'b1, 1'b0, 1'b0);
    nvec++;
    if (generation4 !== 4'hF) begin
      nmis++;
      $display("FAIL sat4: got gen=%h, want gen=%h", generation4, 4'hF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
